sum_status_pipe: RTL and testbench

- Parametrised multi-channel adder/accumulator with per-channel status classification.
- Adds a valid/ready handshake on both sides and a 2-entry output buffer, so it sustains one transaction per cycle under backpressure.
- Sits between a Chisel-generated producer and consumer.
- Per-channel results and status are exposed as flat packed vectors, one lane per channel, for readable Verilator C++.

---
 rtl/sum_status_pipe.sv | 109 ++++++++++
 tb/tb_sum_status_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_status_pipe.sv
// rtl/sum_status_pipe.sv - multi-lane adder/accumulator with per-lane status and a 2-entry output FIFO
module sum_status_pipe #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         mode,
    input  logic                         acc_clr,
    input  logic [CHANNELS*WIDTH-1:0]    a,
    input  logic [CHANNELS*WIDTH-1:0]    b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*WIDTH-1:0]    sum,
    output logic [CHANNELS*2-1:0]        status,
    output logic [CNT_W-1:0]             xfer_count
);

    localparam int DW = CHANNELS * WIDTH;
    localparam int SW = CHANNELS * 2;

    logic [1:0]    count;
    logic [DW-1:0] acc;
    logic [DW-1:0] res;
    logic [SW-1:0] st;
    logic [DW-1:0] tail_sum;
    logic [SW-1:0] tail_status;
    logic          in_fire;
    logic          out_fire;

    // in_ready depends only on buffer occupancy (and reset), never on out_ready
    assign in_ready  = !rst && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_lane
            logic [WIDTH-1:0] base;
            logic [WIDTH-1:0] addend;
            logic [WIDTH:0]   raw;
            logic             ovf;
            logic [WIDTH-1:0] lane_res;

            assign base     = mode ? (acc_clr ? '0 : acc[i*WIDTH +: WIDTH]) : a[i*WIDTH +: WIDTH];
            assign addend   = mode ? a[i*WIDTH +: WIDTH] : b[i*WIDTH +: WIDTH];
            assign raw      = {1'b0, base} + {1'b0, addend};
            assign ovf      = raw[WIDTH];
            assign lane_res = ((SATURATE != 0) && ovf) ? '1 : raw[WIDTH-1:0];

            assign res[i*WIDTH +: WIDTH] = lane_res;
            // overflow wins even when the saturated result is all-ones
            assign st[2*i +: 2] = ovf                ? 2'b11 :
                                  (lane_res == '0)   ? 2'b00 :
                                  (lane_res == '1)   ? 2'b01 : 2'b10;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= 2'd0;
            acc         <= '0;
            sum         <= '0;
            status      <= '0;
            tail_sum    <= '0;
            tail_status <= '0;
            xfer_count  <= '0;
        end else begin
            if (in_fire) begin
                acc <= res;
            end
            if (out_fire) begin
                xfer_count <= xfer_count + 1'b1;
            end
            // sum/status is the head register; the tail only holds the second entry
            case ({in_fire, out_fire})
                2'b10: begin
                    if (count == 2'd0) begin
                        sum    <= res;
                        status <= st;
                    end else begin
                        tail_sum    <= res;
                        tail_status <= st;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        sum    <= tail_sum;
                        status <= tail_status;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    sum    <= res;
                    status <= st;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_status_pipe.sv
// tb/tb_sum_status_pipe.sv - self-checking bench for sum_status_pipe (wrap and saturating instances)
module tb_sum_status_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        mode = 1'b0;
    logic        acc_clr = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        in_ready0, out_valid0, in_ready1, out_valid1;
    logic [31:0] sum0, sum1;
    logic [7:0]  status0, status1;
    logic [15:0] xfer0;
    logic [3:0]  xfer1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sum_status_pipe #(.WIDTH(8), .CHANNELS(4), .SATURATE(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .mode(mode), .acc_clr(acc_clr), .a(a), .b(b),
        .out_valid(out_valid0), .out_ready(out_ready),
        .sum(sum0), .status(status0), .xfer_count(xfer0)
    );

    sum_status_pipe #(.WIDTH(8), .CHANNELS(4), .SATURATE(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .mode(mode), .acc_clr(acc_clr), .a(a), .b(b),
        .out_valid(out_valid1), .out_ready(out_ready),
        .sum(sum1), .status(status1), .xfer_count(xfer1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference: one lane of arithmetic from plain integers
    function automatic void lane_ref(input int base, input int add, input bit sat,
                                     output int res, output logic [1:0] st);
        int  raw;
        bit  ovf;
        raw = base + add;
        ovf = (raw > 255);
        res = (sat && ovf) ? 255 : (raw % 256);
        st  = ovf ? 2'b11 : (res == 0) ? 2'b00 : (res == 255) ? 2'b01 : 2'b10;
    endfunction

    typedef struct {
        logic [31:0] s0;
        logic [7:0]  t0;
        logic [31:0] s1;
        logic [7:0]  t1;
    } ent_t;

    ent_t mq[$];
    int   acc0[4];
    int   acc1[4];
    int   nx = 0;

    always @(negedge clk) begin
        ent_t        e;
        int          r;
        int          bs;
        int          ad;
        logic [1:0]  s;
        bit          inf;
        bit          outf;
        if (rst) begin
            mq.delete();
            for (int i = 0; i < 4; i++) begin
                acc0[i] = 0;
                acc1[i] = 0;
            end
            nx = 0;
            chk("rst_sum0", sum0, 0);
            chk("rst_status0", status0, 0);
            chk("rst_sum1", sum1, 0);
            chk("rst_status1", status1, 0);
        end
        chk("m_in_ready0", in_ready0, (!rst && mq.size() < 2));
        chk("m_in_ready1", in_ready1, (!rst && mq.size() < 2));
        chk("m_out_valid0", out_valid0, (mq.size() > 0));
        chk("m_out_valid1", out_valid1, (mq.size() > 0));
        chk("m_xfer0", xfer0, nx % 65536);
        chk("m_xfer1", xfer1, nx % 16);
        if (mq.size() > 0) begin
            chk("m_sum0", sum0, mq[0].s0);
            chk("m_status0", status0, mq[0].t0);
            chk("m_sum1", sum1, mq[0].s1);
            chk("m_status1", status1, mq[0].t1);
        end
        if (!rst) begin
            inf  = in_valid && (mq.size() < 2);
            outf = (mq.size() > 0) && out_ready;
            if (outf) begin
                void'(mq.pop_front());
                nx++;
            end
            if (inf) begin
                for (int i = 0; i < 4; i++) begin
                    ad = mode ? int'(a[i*8 +: 8]) : int'(b[i*8 +: 8]);
                    bs = mode ? (acc_clr ? 0 : acc0[i]) : int'(a[i*8 +: 8]);
                    lane_ref(bs, ad, 1'b0, r, s);
                    e.s0[i*8 +: 8] = r[7:0];
                    e.t0[2*i +: 2] = s;
                    acc0[i] = r;
                    bs = mode ? (acc_clr ? 0 : acc1[i]) : int'(a[i*8 +: 8]);
                    lane_ref(bs, ad, 1'b1, r, s);
                    e.s1[i*8 +: 8] = r[7:0];
                    e.t1[2*i +: 2] = s;
                    acc1[i] = r;
                end
                mq.push_back(e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          k;
        int          c;
        int          nf;
        logic        rdy;
        logic [7:0]  av;
        logic [7:0]  bv;

        cyc();
        cyc();
        chk("lit_in_ready_in_rst", in_ready0, 0);
        rst = 1'b0;
        cyc();
        chk("lit_in_ready_after_rst", in_ready0, 1);
        chk("lit_out_valid_after_rst", out_valid0, 0);

        // add with wrap / saturate
        a = {8'd3, 8'd200, 8'd255, 8'd0};
        b = {8'd4, 8'd100, 8'd0, 8'd0};
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("lit_add_valid", out_valid0, 1);
        chk("lit_add_sum0", sum0, {8'd7, 8'd44, 8'd255, 8'd0});
        chk("lit_add_status0", status0, 8'b10_11_01_00);
        chk("lit_add_sum1", sum1, {8'd7, 8'd255, 8'd255, 8'd0});
        chk("lit_add_status1", status1, 8'b10_11_01_00);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("lit_add_xfer", xfer0, 1);
        chk("lit_add_drained", out_valid0, 0);

        a = {8'd0, 8'd0, 8'd254, 8'd128};
        b = {8'd0, 8'd0, 8'd1, 8'd128};
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("lit_sat_sum1", sum1, {8'd0, 8'd0, 8'd255, 8'd255});
        chk("lit_sat_status1", status1, 8'b00_00_01_11);
        chk("lit_wrap_sum0", sum0, {8'd0, 8'd0, 8'd255, 8'd0});
        chk("lit_wrap_status0", status0, 8'b00_00_01_11);
        out_ready = 1'b1;
        cyc();

        // accumulate at full rate
        mode = 1'b1;
        acc_clr = 1'b1;
        a = {4{8'd10}};
        in_valid = 1'b1;
        cyc();
        chk("lit_acc_10", sum0, {4{8'd10}});
        chk("lit_acc_10_status", status0, 8'hAA);
        acc_clr = 1'b0;
        a = {4{8'd20}};
        cyc();
        chk("lit_acc_30", sum0, {4{8'd30}});
        cyc();
        chk("lit_acc_50", sum0, {4{8'd50}});
        chk("lit_acc_50_sat", sum1, {4{8'd50}});
        acc_clr = 1'b1;
        a = {4{8'd5}};
        cyc();
        chk("lit_acc_5", sum0, {4{8'd5}});
        in_valid = 1'b0;
        cyc();
        out_ready = 1'b0;
        mode = 1'b0;
        acc_clr = 1'b0;
        chk("lit_acc_xfer", xfer0, 6);

        // backpressure: 5 transactions, consumer stalled for 4 cycles
        k = 0;
        c = 0;
        while ((k < 5 || out_valid0) && c < 60) begin
            if (c >= 1 && c <= 4) chk("lit_bp_head", sum0, {4{8'h01}});
            if (c == 2 || c == 3) chk("lit_bp_in_ready_low", in_ready0, 0);
            out_ready = (c >= 4);
            in_valid = (k < 5);
            av = 8'(k * 10 + 1);
            bv = 8'(k);
            a = {4{av}};
            b = {4{bv}};
            rdy = in_ready0;
            cyc();
            if (rdy && in_valid) k++;
            c++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("lit_bp_in_budget", (c < 60), 1);
        chk("lit_bp_xfer", xfer0, 11);

        // reset with two entries buffered
        a = {4{8'd9}};
        b = {4{8'd9}};
        in_valid = 1'b1;
        cyc();
        cyc();
        in_valid = 1'b0;
        chk("lit_pre_rst_valid", out_valid0, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("lit_mid_rst_valid", out_valid0, 0);
        chk("lit_mid_rst_xfer0", xfer0, 0);
        chk("lit_mid_rst_xfer1", xfer1, 0);
        chk("lit_mid_rst_in_ready", in_ready0, 1);
        mode = 1'b1;
        a = {4{8'd1}};
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("lit_acc_after_rst", sum0, {4{8'd1}});
        out_ready = 1'b1;
        cyc();

        // full throughput with random operands
        nf = 0;
        in_valid = 1'b1;
        for (int j = 0; j < 100; j++) begin
            a = $urandom;
            b = $urandom;
            mode = 1'($urandom_range(0, 1));
            acc_clr = ($urandom_range(0, 3) == 0);
            chk("lit_thr_in_ready", in_ready0, 1);
            if (out_valid0) nf++;
            cyc();
        end
        in_valid = 1'b0;
        if (out_valid0) nf++;
        cyc();
        out_ready = 1'b0;
        chk("lit_thr_fires", nf, 100);
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
